// File: rtl/spaceship_rotation_if.sv
// Purpose: bundles the frame-synchronous control inputs and the heading
//          outputs of the spaceship rotation controller.
// Signals:
//   frame_tick  1-cycle pulse at start of vertical blank
//   btn_cw      rotate clockwise button, asynchronous level
//   btn_ccw     rotate counter-clockwise button, asynchronous level
//   recenter    synchronous 1-cycle pulse, forces heading to its initial value
//   angle       current heading, fed to the renderer
//   rot_step    1-cycle pulse in the cycle angle takes a stepped value
//   rot_active  high while a button press is being tracked
// Modports: master drives the inputs (system/bench), slave is the controller.
interface spaceship_rotation_if #(
    parameter int unsigned ANGLE_W = 4
);
    logic               frame_tick;
    logic               btn_cw;
    logic               btn_ccw;
    logic               recenter;
    logic [ANGLE_W-1:0] angle;
    logic               rot_step;
    logic               rot_active;

    modport master (
        output frame_tick, btn_cw, btn_ccw, recenter,
        input  angle, rot_step, rot_active
    );

    modport slave (
        input  frame_tick, btn_cw, btn_ccw, recenter,
        output angle, rot_step, rot_active
    );
endinterface

// File: rtl/spaceship_rotation_ctrl.sv
// Purpose: owns the spaceship heading. Rotate buttons are synchronised and
//          acted on only at frame_tick, so the renderer sees a stable angle
//          during active video. A tap gives one step; a hold gives one step,
//          then auto-repeats after REPEAT_DELAY frames every REPEAT_RATE frames.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   spaceship_rotation_if.slave (frame_tick, buttons, recenter in;
//         angle, rot_step, rot_active out, all registered)
module spaceship_rotation_ctrl #(
    parameter int unsigned ANGLE_W      = 4,
    parameter int unsigned INIT_ANGLE   = 0,
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned CNT_W        = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    spaceship_rotation_if.slave  bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_e;
    typedef enum logic [1:0] {DIR_NONE, DIR_CW, DIR_CCW} dir_e;

    localparam logic [ANGLE_W-1:0] ANGLE_INIT = ANGLE_W'(INIT_ANGLE);
    localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]   RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    // NOTE: buttons are asynchronous; the first stage may go metastable, so
    // only the second stage is ever decoded.
    logic cw_meta_q,  cw_meta_d,  cw_sync_q,  cw_sync_d;
    logic ccw_meta_q, ccw_meta_d, ccw_sync_q, ccw_sync_d;

    state_e             state_q, state_d;
    dir_e               cur_dir_q, cur_dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               rot_step_q, rot_step_d;
    logic               rot_active_q, rot_active_d;

    dir_e dir;
    logic do_step;

    // Both buttons at once cancel out, same as neither.
    assign dir = (cw_sync_q && !ccw_sync_q) ? DIR_CW  :
                 (ccw_sync_q && !cw_sync_q) ? DIR_CCW : DIR_NONE;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // branches below can leave one unassigned and infer a latch.
        cw_meta_d  = bus.btn_cw;
        cw_sync_d  = cw_meta_q;
        ccw_meta_d = bus.btn_ccw;
        ccw_sync_d = ccw_meta_q;
        state_d    = state_q;
        cur_dir_d  = cur_dir_q;
        cnt_d      = cnt_q;
        angle_d    = angle_q;
        rot_step_d = 1'b0;
        do_step    = 1'b0;

        if (bus.recenter) begin
            // Recenter outranks a coincident tick; a still-held button re-arms
            // from IDLE on the following tick.
            angle_d   = ANGLE_INIT;
            state_d   = ST_IDLE;
            cur_dir_d = DIR_NONE;
            cnt_d     = '0;
        end else if (bus.frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (dir != DIR_NONE) begin
                        do_step   = 1'b1;
                        cur_dir_d = dir;
                        cnt_d     = '0;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (dir == DIR_NONE) begin
                        state_d = ST_IDLE;
                    end else if (dir != cur_dir_q) begin
                        do_step   = 1'b1;
                        cur_dir_d = dir;
                        cnt_d     = '0;
                    end else if (cnt_q == DELAY_LAST) begin
                        do_step = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (dir == DIR_NONE) begin
                        state_d = ST_IDLE;
                    end else if (dir != cur_dir_q) begin
                        do_step   = 1'b1;
                        cur_dir_d = dir;
                        cnt_d     = '0;
                        state_d   = ST_HOLD;
                    end else if (cnt_q == RATE_LAST) begin
                        do_step = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A step always moves in the currently decoded direction; the
            // angle wraps naturally through the ANGLE_W-bit adder.
            if (do_step) begin
                angle_d    = (dir == DIR_CW) ? angle_q + ANGLE_W'(1)
                                             : angle_q - ANGLE_W'(1);
                rot_step_d = 1'b1;
            end
        end

        rot_active_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cw_meta_q    <= 1'b0;
            cw_sync_q    <= 1'b0;
            ccw_meta_q   <= 1'b0;
            ccw_sync_q   <= 1'b0;
            state_q      <= ST_IDLE;
            cur_dir_q    <= DIR_NONE;
            cnt_q        <= '0;
            angle_q      <= ANGLE_INIT;
            rot_step_q   <= 1'b0;
            rot_active_q <= 1'b0;
        end else begin
            cw_meta_q    <= cw_meta_d;
            cw_sync_q    <= cw_sync_d;
            ccw_meta_q   <= ccw_meta_d;
            ccw_sync_q   <= ccw_sync_d;
            state_q      <= state_d;
            cur_dir_q    <= cur_dir_d;
            cnt_q        <= cnt_d;
            angle_q      <= angle_d;
            rot_step_q   <= rot_step_d;
            rot_active_q <= rot_active_d;
        end
    end

    assign bus.angle      = angle_q;
    assign bus.rot_step   = rot_step_q;
    assign bus.rot_active = rot_active_q;

endmodule

// File: tb/tb_spaceship_rotation_ctrl.sv
// Bench for spaceship_rotation_ctrl: directed scenarios with fixed expected
// values, then randomized stimulus compared against a press-duration model.
module tb_spaceship_rotation_ctrl;

    localparam int ANGLE_W = 4;
    localparam int NA      = 1 << ANGLE_W;
    localparam int INIT    = 0;
    localparam int D       = 12;
    localparam int R       = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spaceship_rotation_if #(.ANGLE_W(ANGLE_W)) bus ();

    spaceship_rotation_ctrl #(
        .ANGLE_W(ANGLE_W), .INIT_ANGLE(INIT), .REPEAT_DELAY(D),
        .REPEAT_RATE(R), .CNT_W(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a press is a run of ticks with one decoded direction;
    // steps land at ticks 0, D, D+R, D+2R, ... of the run.
    int m_angle, m_dir, m_held;
    bit m_step;
    bit c1cw, c2cw, c1ccw, c2ccw;   // button level one and two edges ago

    task automatic clk_cycle();
        int d;
        @(posedge clk);
        if (rst) begin
            m_angle = INIT; m_dir = 0; m_held = 0; m_step = 0;
            c1cw = 0; c2cw = 0; c1ccw = 0; c2ccw = 0;
        end else begin
            d = (c2cw && !c2ccw) ? 1 : (c2ccw && !c2cw) ? -1 : 0;
            c2cw = c1cw;   c1cw = bus.btn_cw;
            c2ccw = c1ccw; c1ccw = bus.btn_ccw;
            m_step = 0;
            if (bus.recenter) begin
                m_angle = INIT; m_dir = 0; m_held = 0;
            end else if (bus.frame_tick) begin
                if (d == 0) begin
                    m_dir = 0;
                end else if (d != m_dir) begin
                    m_dir = d; m_held = 0; m_step = 1;
                end else begin
                    m_held++;
                    if (m_held >= D && (m_held - D) % R == 0) m_step = 1;
                end
                if (m_step) m_angle = (m_angle + d + NA) % NA;
            end
        end
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        clk_cycle();
        bus.frame_tick = 1'b0;
    endtask

    task automatic pulse_recenter();
        bus.recenter = 1'b1;
        clk_cycle();
        bus.recenter = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gap(3);
        rst = 1'b0;
        checks++;
        if (bus.angle !== 4'd0 || bus.rot_step !== 1'b0 || bus.rot_active !== 1'b0) begin
            errors++;
            $display("FAIL reset: angle=%0d step=%b active=%b, want 0 0 0",
                     bus.angle, bus.rot_step, bus.rot_active);
        end
        for (int k = 0; k < 3; k++) begin
            gap(3);
            tick();
            checks++;
            if (bus.angle !== 4'd0 || bus.rot_step !== 1'b0 || bus.rot_active !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_tick%0d: angle=%0d step=%b active=%b, want 0 0 0",
                         k, bus.angle, bus.rot_step, bus.rot_active);
            end
        end
    endtask

    task automatic test_tap();
        bus.btn_cw = 1'b1;
        gap(3);
        tick();
        bus.btn_cw = 1'b0;
        checks++;
        if (bus.angle !== 4'd1 || bus.rot_step !== 1'b1 || bus.rot_active !== 1'b1) begin
            errors++;
            $display("FAIL tap_step: angle=%0d step=%b active=%b, want 1 1 1",
                     bus.angle, bus.rot_step, bus.rot_active);
        end
        clk_cycle();
        checks++;
        if (bus.rot_step !== 1'b0 || bus.angle !== 4'd1) begin
            errors++;
            $display("FAIL tap_pulse_width: step=%b angle=%0d, want 0 1", bus.rot_step, bus.angle);
        end
        gap(3);
        tick();
        checks++;
        if (bus.angle !== 4'd1 || bus.rot_active !== 1'b0 || bus.rot_step !== 1'b0) begin
            errors++;
            $display("FAIL tap_release: angle=%0d active=%b step=%b, want 1 0 0",
                     bus.angle, bus.rot_active, bus.rot_step);
        end
    endtask

    task automatic test_hold_wrap();
        logic [3:0] exp_a;
        logic       exp_s;
        pulse_recenter();
        bus.btn_ccw = 1'b1;
        gap(3);
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_a = (k < 12) ? 4'd15 : (k < 16) ? 4'd14 : 4'd13;
            exp_s = (k == 0 || k == 12 || k == 16);
            checks++;
            if (bus.angle !== exp_a || bus.rot_step !== exp_s || bus.rot_active !== 1'b1) begin
                errors++;
                $display("FAIL hold_wrap_tick%0d: angle=%0d step=%b active=%b, want %0d %b 1",
                         k, bus.angle, bus.rot_step, bus.rot_active, exp_a, exp_s);
            end
            gap(3);
        end
        bus.btn_ccw = 1'b0;
        gap(3);
        tick();
        checks++;
        if (bus.rot_active !== 1'b0 || bus.angle !== 4'd13) begin
            errors++;
            $display("FAIL hold_release: active=%b angle=%0d, want 0 13", bus.rot_active, bus.angle);
        end
    endtask

    task automatic test_both_reverse();
        pulse_recenter();
        bus.btn_cw = 1'b1;
        gap(3);
        for (int k = 0; k < 3; k++) begin
            tick();
            gap(3);
        end
        bus.btn_ccw = 1'b1;
        gap(3);
        tick();
        checks++;
        if (bus.angle !== 4'd1 || bus.rot_step !== 1'b0 || bus.rot_active !== 1'b0) begin
            errors++;
            $display("FAIL both_pressed: angle=%0d step=%b active=%b, want 1 0 0",
                     bus.angle, bus.rot_step, bus.rot_active);
        end
        bus.btn_cw = 1'b0;
        gap(3);
        tick();
        checks++;
        if (bus.angle !== 4'd0 || bus.rot_step !== 1'b1 || bus.rot_active !== 1'b1) begin
            errors++;
            $display("FAIL reverse_ccw: angle=%0d step=%b active=%b, want 0 1 1",
                     bus.angle, bus.rot_step, bus.rot_active);
        end
        bus.btn_ccw = 1'b0;
        gap(3);
        tick();
    endtask

    task automatic test_recenter();
        pulse_recenter();
        for (int k = 0; k < 7; k++) begin
            bus.btn_cw = 1'b1;
            gap(3);
            tick();
            bus.btn_cw = 1'b0;
            gap(3);
            tick();
        end
        checks++;
        if (bus.angle !== 4'd7) begin
            errors++;
            $display("FAIL recenter_setup: angle=%0d, want 7", bus.angle);
        end
        bus.btn_cw = 1'b1;
        gap(3);
        bus.recenter   = 1'b1;
        bus.frame_tick = 1'b1;
        clk_cycle();
        bus.recenter   = 1'b0;
        bus.frame_tick = 1'b0;
        checks++;
        if (bus.angle !== 4'd0 || bus.rot_step !== 1'b0 || bus.rot_active !== 1'b0) begin
            errors++;
            $display("FAIL recenter_vs_tick: angle=%0d step=%b active=%b, want 0 0 0",
                     bus.angle, bus.rot_step, bus.rot_active);
        end
        gap(3);
        tick();
        checks++;
        if (bus.angle !== 4'd1 || bus.rot_step !== 1'b1 || bus.rot_active !== 1'b1) begin
            errors++;
            $display("FAIL recenter_rearm: angle=%0d step=%b active=%b, want 1 1 1",
                     bus.angle, bus.rot_step, bus.rot_active);
        end
        bus.btn_cw = 1'b0;
        gap(3);
        tick();
    endtask

    task automatic test_sync_timing();
        pulse_recenter();
        gap(3);
        bus.btn_cw = 1'b1;          // present at 2 edges up to and including the tick edge
        clk_cycle();
        tick();
        checks++;
        if (bus.rot_step !== 1'b0 || bus.angle !== 4'd0 || bus.rot_active !== 1'b0) begin
            errors++;
            $display("FAIL sync_1clk: step=%b angle=%0d active=%b, want 0 0 0",
                     bus.rot_step, bus.angle, bus.rot_active);
        end
        bus.btn_cw = 1'b0;
        gap(4);
        bus.btn_cw = 1'b1;          // present at 3 edges up to and including the tick edge
        gap(2);
        tick();
        checks++;
        if (bus.rot_step !== 1'b1 || bus.angle !== 4'd1) begin
            errors++;
            $display("FAIL sync_2clk: step=%b angle=%0d, want 1 1", bus.rot_step, bus.angle);
        end
        bus.btn_cw = 1'b0;
        gap(3);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(599) == 0);
            bus.frame_tick = ($urandom_range(3) == 0);
            bus.recenter   = ($urandom_range(63) == 0);
            if ($urandom_range(127) == 0) bus.btn_cw  = ~bus.btn_cw;
            if ($urandom_range(127) == 0) bus.btn_ccw = ~bus.btn_ccw;
            clk_cycle();
            checks++;
            if (bus.angle !== ANGLE_W'(m_angle) || bus.rot_step !== m_step ||
                bus.rot_active !== (m_dir != 0)) begin
                errors++;
                $display("FAIL random_cycle%0d: angle=%0d step=%b active=%b, want %0d %b %b",
                         i, bus.angle, bus.rot_step, bus.rot_active,
                         m_angle, m_step, (m_dir != 0));
            end
        end
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        bus.recenter   = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_cw     = 1'b0;
        bus.btn_ccw    = 1'b0;
        bus.recenter   = 1'b0;
        test_reset();
        test_tap();
        test_hold_wrap();
        test_both_reverse();
        test_recenter();
        test_sync_timing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
